comm_master: RTL and testbench

Host-side UART command master for the quadcopter bench. It serializes one command frame (command byte followed by a 16-bit data word) onto its TX line and receives the one-byte response the copter returns on RX. It sits outside the flight controller and drives the controller's RX pin through a wireless-link stand-in. Completion and response-ready are reported as level flags.

---
 rtl/comm_pkg.sv | 14 +
 rtl/uart_trx.sv | 115 +++++++++++
 rtl/comm_master.sv | 144 ++++++++++++++
 tb/tb_comm_master.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/comm_pkg.sv
// Shared types and constants for the quadcopter command master.
package comm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMD     = 2'd1,
    DATA_HI = 2'd2,
    DATA_LO = 2'd3
  } frm_state_e;

  localparam int         DEF_BAUD_DIV = 2604;
  localparam logic [7:0] TIMEOUT_RESP = 8'hEE;

endpackage

// File: rtl/uart_trx.sv
// 8N1 UART transmitter/receiver pair; tx byte spans 10*BAUD_DIV clocks, rx_rdy pulses at mid-stop.
// trmt is ignored while a byte is in flight; the receiver never stalls.
module uart_trx
  import comm_pkg::*;
#(
  parameter int BAUD_DIV = DEF_BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done,
  input  logic       RX,
  output logic       rx_rdy,
  output logic [7:0] rx_data
);

  localparam int            CW        = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

  logic          tx_busy_q;
  logic [9:0]    tx_shift_q;
  logic [CW-1:0] tx_baud_q;
  logic [3:0]    tx_bit_q;
  logic          tx_bit_end;

  assign tx_bit_end = tx_busy_q && (tx_baud_q == BAUD_LAST);
  assign tx_done    = tx_bit_end && (tx_bit_q == 4'd9);
  assign TX         = tx_shift_q[0];

  // Shifting in ones leaves the line high once the stop bit has gone out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy_q  <= 1'b0;
      tx_shift_q <= '1;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
    end else if (!tx_busy_q) begin
      if (trmt) begin
        tx_busy_q  <= 1'b1;
        tx_shift_q <= {1'b1, tx_data, 1'b0};
        tx_baud_q  <= '0;
        tx_bit_q   <= '0;
      end
    end else if (tx_bit_end) begin
      tx_baud_q  <= '0;
      tx_shift_q <= {1'b1, tx_shift_q[9:1]};
      tx_bit_q   <= tx_bit_q + 4'd1;
      if (tx_done) tx_busy_q <= 1'b0;
    end else begin
      tx_baud_q <= tx_baud_q + 1'b1;
    end
  end

  logic          rx_s1_q, rx_s2_q, rx_s3_q;
  logic          rx_busy_q;
  logic [CW-1:0] rx_baud_q;
  logic [3:0]    rx_bit_q;
  logic [7:0]    rx_shift_q;
  logic          rx_rdy_q;
  logic [7:0]    rx_data_q;

  assign rx_rdy  = rx_rdy_q;
  assign rx_data = rx_data_q;

  // rx_bit_q 0 is the start-bit qualification phase, 1..8 data, 9 stop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      rx_busy_q  <= 1'b0;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_rdy_q   <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      rx_s1_q  <= RX;
      rx_s2_q  <= rx_s1_q;
      rx_s3_q  <= rx_s2_q;
      rx_rdy_q <= 1'b0;
      if (!rx_busy_q) begin
        if (rx_s3_q && !rx_s2_q) begin
          rx_busy_q <= 1'b1;
          rx_baud_q <= '0;
          rx_bit_q  <= '0;
        end
      end else if (rx_bit_q == 4'd0) begin
        if (rx_baud_q == HALF_LAST) begin
          rx_baud_q <= '0;
          if (rx_s2_q) rx_busy_q <= 1'b0;
          else         rx_bit_q  <= 4'd1;
        end else begin
          rx_baud_q <= rx_baud_q + 1'b1;
        end
      end else if (rx_baud_q == BAUD_LAST) begin
        rx_baud_q <= '0;
        if (rx_bit_q == 4'd9) begin
          rx_busy_q <= 1'b0;
          rx_rdy_q  <= 1'b1;
          rx_data_q <= rx_shift_q;
        end else begin
          rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
          rx_bit_q   <= rx_bit_q + 4'd1;
        end
      end else begin
        rx_baud_q <= rx_baud_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/comm_master.sv
// UART command master: sends cmd,data_hi,data_lo; frm_snt 30*BAUD_DIV+3 clocks after snd_cmd, snd_cmd ignored while busy.
// Optional response timeout under COMM_MASTER_TIMEOUT_EN.
module comm_master
  import comm_pkg::*;
#(
  parameter int BAUD_DIV     = DEF_BAUD_DIV,
  parameter int RESP_TIMEOUT = 2_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  input  logic        snd_cmd,
  output logic        frm_snt,
  output logic        resp_rdy,
  output logic [7:0]  resp
);

  if (BAUD_DIV < 4 || RESP_TIMEOUT < 1) begin : g_param_check
    $error("comm_master: BAUD_DIV must be >= 4 and RESP_TIMEOUT >= 1");
  end

  frm_state_e  state_q;
  logic [15:0] data_q;
  logic [7:0]  tx_byte_q;
  logic        trmt_q;
  logic        frm_snt_q;
  logic        resp_rdy_q;
  logic [7:0]  resp_q;

  logic        tx_done, rx_rdy, tmo_fire, accept, frm_set;
  logic [7:0]  rx_data;

  assign accept   = (state_q == IDLE) && snd_cmd;
  assign frm_set  = (state_q == DATA_LO) && tx_done;
  assign frm_snt  = frm_snt_q;
  assign resp_rdy = resp_rdy_q;
  assign resp     = resp_q;

  uart_trx #(.BAUD_DIV(BAUD_DIV)) u_trx (
    .clk    (clk),
    .rst_n  (rst_n),
    .trmt   (trmt_q),
    .tx_data(tx_byte_q),
    .TX     (TX),
    .tx_done(tx_done),
    .RX     (RX),
    .rx_rdy (rx_rdy),
    .rx_data(rx_data)
  );

  // Next byte is queued on the same edge the previous stop bit ends, leaving one idle clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      data_q    <= '0;
      tx_byte_q <= '0;
      trmt_q    <= 1'b0;
      frm_snt_q <= 1'b0;
    end else begin
      trmt_q <= 1'b0;
      case (state_q)
        IDLE: if (snd_cmd) begin
          state_q   <= CMD;
          tx_byte_q <= cmd;
          data_q    <= data;
          trmt_q    <= 1'b1;
          frm_snt_q <= 1'b0;
        end
        CMD: if (tx_done) begin
          state_q   <= DATA_HI;
          tx_byte_q <= data_q[15:8];
          trmt_q    <= 1'b1;
        end
        DATA_HI: if (tx_done) begin
          state_q   <= DATA_LO;
          tx_byte_q <= data_q[7:0];
          trmt_q    <= 1'b1;
        end
        DATA_LO: if (tx_done) begin
          state_q   <= IDLE;
          frm_snt_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef COMM_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(RESP_TIMEOUT + 1);

  logic          tmo_run_q;
  logic [TW-1:0] tmo_cnt_q;

  assign tmo_fire = tmo_run_q && (tmo_cnt_q == TW'(RESP_TIMEOUT - 1)) && !rx_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_run_q <= 1'b0;
      tmo_cnt_q <= '0;
    end else if (accept || rx_rdy || tmo_fire) begin
      tmo_run_q <= 1'b0;
      tmo_cnt_q <= '0;
    end else if (frm_set) begin
      tmo_run_q <= 1'b1;
      tmo_cnt_q <= '0;
    end else if (tmo_run_q) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end
`else
  assign tmo_fire = 1'b0;
`endif

  logic       resp_rdy_d;
  logic [7:0] resp_d;

  // A response landing in the same cycle as a new command keeps resp_rdy set.
  always_comb begin
    resp_rdy_d = resp_rdy_q;
    resp_d     = resp_q;
    if (accept)        resp_rdy_d = 1'b0;
    if (rx_rdy) begin
      resp_rdy_d = 1'b1;
      resp_d     = rx_data;
    end else if (tmo_fire) begin
      resp_rdy_d = 1'b1;
      resp_d     = TIMEOUT_RESP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_rdy_q <= 1'b0;
      resp_q     <= '0;
    end else begin
      resp_rdy_q <= resp_rdy_d;
      resp_q     <= resp_d;
    end
  end

endmodule

// File: tb/tb_comm_master.sv
// Bench for comm_master: table-driven frames, random responses, UART decoder on TX.
module tb_comm_master;

  localparam int BD = 256;
  localparam int RT = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        snd_cmd = 1'b0;
  logic [7:0]  cmd = '0;
  logic [15:0] data = '0;
  logic        TX, frm_snt, resp_rdy;
  logic [7:0]  resp;

  comm_master #(.BAUD_DIV(BD), .RESP_TIMEOUT(RT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (RX),
    .TX      (TX),
    .cmd     (cmd),
    .data    (data),
    .snd_cmd (snd_cmd),
    .frm_snt (frm_snt),
    .resp_rdy(resp_rdy),
    .resp    (resp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
  endtask

  // Reference: the frame is cmd, then the high data byte, then the low data byte.
  function automatic logic [7:0] frame_byte(input logic [7:0] c, input logic [15:0] d, input int k);
    int v;
    if (k == 0) v = c;
    else if (k == 1) v = d / 256;
    else v = d % 256;
    return v[7:0];
  endfunction

  logic [7:0] mon_q[$];
  int         mon_t[$];

  initial begin : tx_mon
    logic [7:0] b;
    int         t0;
    logic       tx_prev;
    tx_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && tx_prev && !TX) begin
        t0 = cyc;
        repeat (BD / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(negedge clk);
          b[i] = TX;
        end
        repeat (BD) @(negedge clk);
        check("tx_stop_bit", {31'd0, TX}, 32'd1);
        mon_q.push_back(b);
        mon_t.push_back(t0);
      end
      tx_prev = TX;
    end
  end

  task automatic send_frame(input logic [7:0] c, input logic [15:0] d, output int t_acc);
    @(negedge clk);
    cmd = c;
    data = d;
    snd_cmd = 1'b1;
    @(negedge clk);
    snd_cmd = 1'b0;
    t_acc = cyc;
    cmd = 8'($urandom);
    data = 16'($urandom);
  endtask

  task automatic send_rx(input logic [7:0] b, output int t);
    t = cyc;
    RX = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BD) @(negedge clk);
    end
    RX = 1'b1;
    repeat (BD) @(negedge clk);
  endtask

  task automatic wait_frm(output int t);
    t = -1;
    for (int i = 0; i < 40 * BD && t < 0; i++) begin
      @(negedge clk);
      if (frm_snt) t = cyc;
    end
  endtask

  task automatic wait_rdy(input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget && t < 0; i++) begin
      @(negedge clk);
      if (resp_rdy) t = cyc;
    end
  endtask

  typedef struct {
    logic [7:0]  c;
    logic [15:0] d;
    logic [7:0]  r;
    logic [7:0]  eb[3];
  } vec_t;

  vec_t tbl[4];

  initial begin
    int t_acc, t_f, t_rx, t_rdy, lat;

    tbl[0].c = 8'h02; tbl[0].d = 16'hA55A; tbl[0].r = 8'h3C;
    for (int i = 1; i < 4; i++) begin
      tbl[i].c = 8'($urandom);
      tbl[i].d = 16'($urandom);
      tbl[i].r = 8'($urandom);
    end
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 3; k++) tbl[i].eb[k] = frame_byte(tbl[i].c, tbl[i].d, k);

    repeat (5) @(negedge clk);
    check("rst_tx", {31'd0, TX}, 32'd1);
    check("rst_frm_snt", {31'd0, frm_snt}, 32'd0);
    check("rst_resp_rdy", {31'd0, resp_rdy}, 32'd0);
    check("rst_resp", {24'd0, resp}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Spec frame plus an attempted overwrite while DATA_HI is on the wire.
    send_frame(8'h02, 16'hA55A, t_acc);
    repeat (15 * BD) @(negedge clk);
    cmd = 8'hFF;
    data = 16'h0000;
    snd_cmd = 1'b1;
    @(negedge clk);
    snd_cmd = 1'b0;
    wait_frm(t_f);
    check("frm_snt_latency", t_f - t_acc, 30 * BD + 3);
    repeat (12 * BD) @(negedge clk);
    check("frm_snt_holds", {31'd0, frm_snt}, 32'd1);
    check("byte_count", mon_q.size(), 3);
    for (int k = 0; k < 3; k++) begin
      if (mon_q.size() > k) begin
        check($sformatf("frame_byte%0d", k), {24'd0, mon_q[k]}, {24'd0, frame_byte(8'h02, 16'hA55A, k)});
        if (k == 0) check("tx_start_delay", mon_t[0] - t_acc, 1);
        else check($sformatf("byte_gap%0d", k), mon_t[k] - mon_t[k-1], 10 * BD + 1);
      end
    end

    @(negedge clk);
    fork
      send_rx(8'hA5, t_rx);
      wait_rdy(12 * BD, t_rdy);
    join
    lat = t_rdy - t_rx;
    check("resp_value", {24'd0, resp}, 32'hA5);
    check("resp_rdy_set", {31'd0, resp_rdy}, 32'd1);
    check("resp_latency_window",
          {31'd0, (lat >= (19 * BD) / 2 + 1) && (lat <= (19 * BD) / 2 + 5)}, 32'd1);

    for (int i = 0; i < 4; i++) begin
      mon_q.delete();
      mon_t.delete();
      send_frame(tbl[i].c, tbl[i].d, t_acc);
      check($sformatf("v%0d_frm_snt_clr", i), {31'd0, frm_snt}, 32'd0);
      check($sformatf("v%0d_resp_rdy_clr", i), {31'd0, resp_rdy}, 32'd0);
      fork
        begin
          repeat ($urandom_range(BD, 15 * BD)) @(negedge clk);
          send_rx(tbl[i].r, t_rx);
        end
        wait_frm(t_f);
      join
      repeat (2) @(negedge clk);
      check($sformatf("v%0d_frm_latency", i), t_f - t_acc, 30 * BD + 3);
      check($sformatf("v%0d_byte_count", i), mon_q.size(), 3);
      for (int k = 0; k < 3; k++)
        if (mon_q.size() > k)
          check($sformatf("v%0d_byte%0d", i, k), {24'd0, mon_q[k]}, {24'd0, tbl[i].eb[k]});
      check($sformatf("v%0d_resp", i), {24'd0, resp}, {24'd0, tbl[i].r});
      check($sformatf("v%0d_resp_rdy", i), {31'd0, resp_rdy}, 32'd1);
    end

    // Frame with no reply; a sub-half-bit RX glitch must not be taken as a byte.
    send_frame(8'h5A, 16'h1234, t_acc);
    repeat (2 * BD) @(negedge clk);
    RX = 1'b0;
    repeat (100) @(negedge clk);
    RX = 1'b1;
    wait_frm(t_f);
    check("glitch_no_resp", {31'd0, resp_rdy}, 32'd0);
`ifdef COMM_MASTER_TIMEOUT_EN
    wait_rdy(RT + 50, t_rdy);
    check("timeout_latency", t_rdy - t_f, RT);
    check("timeout_code", {24'd0, resp}, 32'hEE);
`else
    repeat (RT + 50) @(negedge clk);
    check("no_timeout_rdy", {31'd0, resp_rdy}, 32'd0);
    check("no_timeout_resp", {24'd0, resp}, {24'd0, tbl[3].r});
`endif

    // Reset in the middle of a frame of zeros.
    send_frame(8'h00, 16'h0000, t_acc);
    repeat (3 * BD + BD / 2) @(negedge clk);
    check("abort_tx_low", {31'd0, TX}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort_tx", {31'd0, TX}, 32'd1);
    check("abort_frm_snt", {31'd0, frm_snt}, 32'd0);
    check("abort_resp_rdy", {31'd0, resp_rdy}, 32'd0);
    check("abort_resp", {24'd0, resp}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
